// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 3-stage carry-select adder between NREQ requesters.
// Requester IDs ride a tag pipeline alongside the core so each sum is steered back to its owner.

module csel_adder_core #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             v_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);
  localparam int NB = WIDTH / BLOCK;

  logic             v1, v2;
  logic [WIDTH-1:0] a1, b1;
  logic             c1, c2;
  logic [BLOCK:0]   s0_c [NB];
  logic [BLOCK:0]   s1_c [NB];
  logic [BLOCK:0]   s0_r [NB];
  logic [BLOCK:0]   s1_r [NB];
  logic [BLOCK:0]   sel;
  logic             carry;
  logic [WIDTH-1:0] sum_c;

  // Valid flops only gate data capture; they are deliberately left unreset.
  always_ff @(posedge clk) begin
    v1 <= v_in;
    v2 <= v1;
    if (v_in) begin
      a1 <= a;
      b1 <= b;
      c1 <= cin;
    end
  end

  always_comb begin
    for (int j = 0; j < NB; j++) begin
      s0_c[j] = {1'b0, a1[j*BLOCK +: BLOCK]} + {1'b0, b1[j*BLOCK +: BLOCK]};
      s1_c[j] = s0_c[j] + {{BLOCK{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (v1) begin
      c2 <= c1;
      for (int j = 0; j < NB; j++) begin
        s0_r[j] <= s0_c[j];
        s1_r[j] <= s1_c[j];
      end
    end
  end

  // Block carries ripple only through the select muxes, not through the adders.
  always_comb begin
    carry = c2;
    sel   = '0;
    sum_c = '0;
    for (int j = 0; j < NB; j++) begin
      if (carry) sel = s1_r[j];
      else       sel = s0_r[j];
      sum_c[j*BLOCK +: BLOCK] = sel[BLOCK-1:0];
      carry = sel[BLOCK];
    end
  end

  always_ff @(posedge clk) begin
    if (v2) sum <= sum_c;
  end
endmodule

module adder_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic                  hold,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  busy
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]   ptr;
  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_id;
  logic             found;
  int               idx;
  logic             accept;
  logic             iv;
  logic [IDW-1:0]   id0;
  logic [WIDTH-1:0] a_r, b_r;
  logic             cin_r;
  logic             tv1, tv2, tv3;
  logic [IDW-1:0]   tid1, tid2, tid3;
  logic [WIDTH-1:0] core_sum;

  // First valid requester scanning from ptr+1 around to ptr.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = idx[IDW-1:0];
      end
    end
  end

  assign req_ready = (hold || rst) ? '0 : gnt;
  assign accept    = |req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDW'(NREQ - 1);
      iv  <= 1'b0;
      id0 <= '0;
    end else begin
      iv <= accept;
      if (accept) begin
        ptr <= gnt_id;
        id0 <= gnt_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_r   <= req_a[gnt_id*WIDTH +: WIDTH];
      b_r   <= req_b[gnt_id*WIDTH +: WIDTH];
      cin_r <= req_cin[gnt_id];
    end
  end

  csel_adder_core #(.WIDTH(WIDTH), .BLOCK(BLOCK)) u_core (
    .clk  (clk),
    .v_in (iv),
    .a    (a_r),
    .b    (b_r),
    .cin  (cin_r),
    .sum  (core_sum)
  );

  // Tag pipeline matches the core's three stages so tv3 lines up with core_sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv1 <= 1'b0; tv2 <= 1'b0; tv3 <= 1'b0;
      tid1 <= '0;  tid2 <= '0;  tid3 <= '0;
    end else begin
      tv1 <= iv;  tid1 <= id0;
      tv2 <= tv1; tid2 <= tid1;
      tv3 <= tv2; tid3 <= tid2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_sum   <= '0;
    end else begin
      rsp_valid <= tv3 ? (NREQ'(1) << tid3) : '0;
      if (tv3) rsp_sum <= core_sum;
    end
  end

  assign busy = iv | tv1 | tv2 | tv3 | (|rsp_valid);
endmodule
